// File: rtl/arb_pkg.sv
// Shared defaults and index helpers for the round-robin arbitrating mux.
package arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_IN  = 4;
  localparam int MAX_N_IN  = 16;

  // Round-robin pointer advance; wraps at n-1 so non-power-of-two counts never overrun.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MAX_N_IN-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_N_IN; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_N_IN-1:0] lowest_onehot(input logic [MAX_N_IN-1:0] v);
    return v & (~v + 1'b1);
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant: round-robin from ptr, or fixed priority with input 0 highest.
module rr_grant
  import arb_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  in_valid,
  input  logic [SEL_W-1:0] ptr,
  input  logic             fixed_prio,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [N_IN-1:0] upper_valid;
  logic [N_IN-1:0] upper_grant;
  logic [N_IN-1:0] lower_grant;

  // Fixed mode behaves as round-robin with the search starting at 0.
  always_comb begin
    upper_valid = '0;
    for (int i = 0; i < N_IN; i++) begin
      upper_valid[i] = in_valid[i] && (fixed_prio || (i >= int'(ptr)));
    end
  end

  always_comb begin
    upper_grant = N_IN'(lowest_onehot(MAX_N_IN'(upper_valid)));
    lower_grant = N_IN'(lowest_onehot(MAX_N_IN'(in_valid)));
    grant       = (|upper_valid) ? upper_grant : lower_grant;
    grant_idx   = SEL_W'(onehot_to_idx(MAX_N_IN'(grant)));
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input valid/ready mux with round-robin or fixed-priority arbitration and a registered output.
module rr_arb_mux
  import arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = DEF_N_IN,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic                  fixed_prio,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  rr_grant #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_grant (
    .in_valid   (in_valid),
    .ptr        (ptr_q),
    .fixed_prio (fixed_prio),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Grant only ever selects valid inputs, so masking by can_load completes the handshake.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    in_ready = rst_n ? (grant & {N_IN{can_load}}) : '0;
    xfer     = |in_ready;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = sel_data;
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      if (!fixed_prio) ptr_d = SEL_W'(next_ptr(int'(grant_idx), N_IN));
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-input instance and a 3-input instance for the wrap case.
module tb_rr_arb_mux;

  logic clk;
  logic rst_n;

  logic [4*32-1:0] in_data4;
  logic [3:0]      in_valid4;
  logic [3:0]      in_ready4;
  logic            fixed4;
  logic [31:0]     out_data4;
  logic [1:0]      out_src4;
  logic            out_valid4;
  logic            out_ready4;

  logic [3*32-1:0] in_data3;
  logic [2:0]      in_valid3;
  logic [2:0]      in_ready3;
  logic            fixed3;
  logic [31:0]     out_data3;
  logic [1:0]      out_src3;
  logic            out_valid3;
  logic            out_ready3;

  int errors = 0;
  int checks = 0;

  rr_arb_mux #(.WIDTH(32), .N_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .fixed_prio(fixed4), .out_data(out_data4),
    .out_src(out_src4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  rr_arb_mux #(.WIDTH(32), .N_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .fixed_prio(fixed3), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'hA0 + i;
    for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'hB0 + i;
    in_valid4 = 4'b1111; fixed4 = 1'b0; out_ready4 = 1'b1;
    in_valid3 = 3'b000;  fixed3 = 1'b0; out_ready3 = 1'b1;
    step();
    step();
    checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready4); end
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid4); end
    checks++; if (out_data4 !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data4); end
    checks++; if (out_src4 !== 2'd0) begin errors++; $display("FAIL reset_out_src got=%0d exp=0", out_src4); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready4 !== 4'b0001) begin errors++; $display("FAIL release_in_ready got=%b exp=0001", in_ready4); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (out_src4 !== 2'(k % 4)) begin errors++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", k, out_src4, k % 4); end
      checks++; if (out_data4 !== 32'hA0 + 32'(k % 4)) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, out_data4, 32'hA0 + 32'(k % 4)); end
      checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, out_valid4); end
    end
  endtask

  task automatic test_fixed_prio();
    // two more round-robin grants leave ptr at 2
    step();
    step();
    checks++; if (out_src4 !== 2'd1) begin errors++; $display("FAIL pre_fixed_src got=%0d exp=1", out_src4); end
    fixed4 = 1'b1;
    in_valid4 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (in_ready4 !== 4'b0010) begin errors++; $display("FAIL fixed_ready[%0d] got=%b exp=0010", k, in_ready4); end
      step();
      checks++; if (out_src4 !== 2'd1) begin errors++; $display("FAIL fixed_src[%0d] got=%0d exp=1", k, out_src4); end
    end
    fixed4 = 1'b0;
    #1;
    checks++; if (in_ready4 !== 4'b1000) begin errors++; $display("FAIL switch_ready got=%b exp=1000", in_ready4); end
    step();
    checks++; if (out_src4 !== 2'd3) begin errors++; $display("FAIL switch_src got=%0d exp=3", out_src4); end
    checks++; if (out_data4 !== 32'hA3) begin errors++; $display("FAIL switch_data got=%h exp=000000a3", out_data4); end
  endtask

  task automatic test_backpressure();
    in_data4[0*32 +: 32] = 32'hDEADBEEF;
    in_valid4 = 4'b0001;
    step();
    checks++; if (out_data4 !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_latch got=%h exp=deadbeef", out_data4); end
    out_ready4 = 1'b0;
    in_valid4 = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, in_ready4); end
      step();
      checks++; if (out_data4 !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold[%0d] got=%h exp=deadbeef", k, out_data4); end
      checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, out_valid4); end
    end
    out_ready4 = 1'b1;
    #1;
    checks++; if (in_ready4 !== 4'b0100) begin errors++; $display("FAIL drain_ready got=%b exp=0100", in_ready4); end
    step();
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL drain_valid got=%b exp=1", out_valid4); end
    checks++; if (out_data4 !== 32'hA2) begin errors++; $display("FAIL drain_data got=%h exp=000000a2", out_data4); end
    checks++; if (out_src4 !== 2'd2) begin errors++; $display("FAIL drain_src got=%0d exp=2", out_src4); end
    in_valid4 = 4'b0000;
    step();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL empty_valid got=%b exp=0", out_valid4); end
    checks++; if (out_data4 !== 32'hA2) begin errors++; $display("FAIL empty_hold got=%h exp=000000a2", out_data4); end
  endtask

  task automatic test_reset_mid();
    // ptr is 3 here; granting input 1 leaves ptr at 2 with out_valid set
    in_valid4 = 4'b0010;
    step();
    checks++; if (out_src4 !== 2'd1) begin errors++; $display("FAIL mid_setup_src got=%0d exp=1", out_src4); end
    in_valid4 = 4'b1111;
    out_ready4 = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0000", in_ready4); end
    step();
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid4); end
    rst_n = 1'b1;
    out_ready4 = 1'b1;
    #1;
    checks++; if (in_ready4 !== 4'b0001) begin errors++; $display("FAIL mid_release_ready got=%b exp=0001", in_ready4); end
    step();
    checks++; if (out_src4 !== 2'd0) begin errors++; $display("FAIL mid_first_src got=%0d exp=0", out_src4); end
  endtask

  task automatic test_wrap3();
    in_valid3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (out_src3 !== 2'(k % 3)) begin errors++; $display("FAIL wrap3_src[%0d] got=%0d exp=%0d", k, out_src3, k % 3); end
      checks++; if (out_data3 !== 32'hB0 + 32'(k % 3)) begin errors++; $display("FAIL wrap3_data[%0d] got=%h exp=%h", k, out_data3, 32'hB0 + 32'(k % 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_prio();
    test_backpressure();
    test_reset_mid();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
